// File: rtl/router_pkg.sv
// Shared types and helpers for the NUM_PORTS router control FSM.
package router_pkg;

  typedef enum logic [3:0] {
    ST_DECODE = 4'd0,
    ST_WAIT   = 4'd1,
    ST_LFD    = 4'd2,
    ST_LD     = 4'd3,
    ST_LP     = 4'd4,
    ST_FFS    = 4'd5,
    ST_LAF    = 4'd6,
    ST_CPE    = 4'd7,
    ST_DROP   = 4'd8
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_ports);
    return addr < num_ports;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Up-counter bounding the wait for the destination FIFO to drain.
module router_wait_timer #(
  parameter int WAIT_TIMEOUT = 32,
  parameter int TMR_W        = 6
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] TC      = TMR_W'(WAIT_TIMEOUT - 1);
  localparam bit               ENABLED = (WAIT_TIMEOUT != 0);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + TMR_W'(1);
  end

  // A zero timeout means wait forever; the counter may wrap harmlessly.
  assign o_expired = ENABLED && (r_cnt == TC);

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM for NUM_PORTS output FIFOs with drop, abort and wait timeout.
//   state     | meaning
//   ST_DECODE | idle, waiting for a header
//   ST_WAIT   | destination FIFO not yet empty
//   ST_LFD    | loading header byte
//   ST_LD     | loading payload
//   ST_LP     | loading parity byte
//   ST_FFS    | destination FIFO full, stalled
//   ST_LAF    | resume after full
//   ST_CPE    | parity check
//   ST_DROP   | discarding packet to an invalid port or after timeout
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32,
  parameter int TMR_W        = 6
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_packet_valid,
  input  logic [ADDR_W-1:0]    i_datain,
  input  logic [NUM_PORTS-1:0] i_fifo_full,
  input  logic [NUM_PORTS-1:0] i_fifo_empty,
  input  logic [NUM_PORTS-1:0] i_soft_reset,
  input  logic                 i_parity_done,
  input  logic                 i_low_packet_valid,
  output logic                 o_detect_add,
  output logic                 o_lfd_state,
  output logic                 o_ld_state,
  output logic                 o_laf_state,
  output logic                 o_full_state,
  output logic                 o_rst_int_reg,
  output logic                 o_write_enb_reg,
  output logic                 o_busy,
  output logic                 o_drop_state,
  output logic [ADDR_W-1:0]    o_dest_addr,
  output logic                 o_aborted
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_dest;
  logic              r_aborted, w_abort;
  logic              w_hdr_valid, w_empty_hdr;
  logic              w_empty_dest, w_full_dest, w_srst_dest;
  logic              w_tmr_clr, w_tmr_en, w_tmr_expired;

  // Explicit per-port match keeps addresses beyond NUM_PORTS from indexing out of range.
  always_comb begin
    w_empty_hdr  = 1'b0;
    w_empty_dest = 1'b0;
    w_full_dest  = 1'b0;
    w_srst_dest  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i_datain == ADDR_W'(i)) w_empty_hdr = i_fifo_empty[i];
      if (r_dest == ADDR_W'(i)) begin
        w_empty_dest = i_fifo_empty[i];
        w_full_dest  = i_fifo_full[i];
        w_srst_dest  = i_soft_reset[i];
      end
    end
  end

  assign w_hdr_valid = addr_valid(int'(unsigned'(i_datain)), NUM_PORTS);
  assign w_tmr_en    = (r_state == ST_WAIT);
  assign w_tmr_clr   = !w_tmr_en;

  router_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .TMR_W        (TMR_W)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= ST_DECODE;
      r_dest    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= w_abort;
      if (r_state == ST_DECODE && i_packet_valid) r_dest <= i_datain;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      ST_DECODE: begin
        if (i_packet_valid) begin
          if (!w_hdr_valid)     w_next = ST_DROP;
          else if (w_empty_hdr) w_next = ST_LFD;
          else                  w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_srst_dest) begin
          w_next  = ST_DECODE;
          w_abort = 1'b1;
        end else if (w_empty_dest) begin
          w_next = ST_LFD;
        end else if (w_tmr_expired) begin
          w_next  = ST_DROP;
          w_abort = 1'b1;
        end
      end
      ST_LFD: begin
        if (w_srst_dest) begin
          w_next  = ST_DECODE;
          w_abort = 1'b1;
        end else begin
          w_next = ST_LD;
        end
      end
      ST_LD: begin
        if (w_srst_dest) begin
          w_next  = ST_DECODE;
          w_abort = 1'b1;
        end else if (w_full_dest) begin
          w_next = ST_FFS;
        end else if (!i_packet_valid) begin
          w_next = ST_LP;
        end
      end
      ST_LP:  w_next = ST_CPE;
      ST_FFS: begin
        if (w_srst_dest) begin
          w_next  = ST_DECODE;
          w_abort = 1'b1;
        end else if (!w_full_dest) begin
          w_next = ST_LAF;
        end
      end
      ST_LAF: begin
        if (w_srst_dest) begin
          w_next  = ST_DECODE;
          w_abort = 1'b1;
        end else if (i_parity_done)      w_next = ST_DECODE;
        else if (i_low_packet_valid)     w_next = ST_LP;
        else                             w_next = ST_LD;
      end
      ST_CPE:  w_next = w_full_dest ? ST_FFS : ST_DECODE;
      ST_DROP: if (!i_packet_valid) w_next = ST_DECODE;
      default: w_next = ST_DECODE;
    endcase
  end

  always_comb begin
    o_detect_add    = 1'b0;
    o_lfd_state     = 1'b0;
    o_ld_state      = 1'b0;
    o_laf_state     = 1'b0;
    o_full_state    = 1'b0;
    o_rst_int_reg   = 1'b0;
    o_write_enb_reg = 1'b0;
    o_busy          = 1'b0;
    o_drop_state    = 1'b0;
    case (r_state)
      ST_DECODE: o_detect_add = 1'b1;
      ST_WAIT:   o_busy       = 1'b1;
      ST_LFD: begin
        o_lfd_state = 1'b1;
        o_busy      = 1'b1;
      end
      ST_LD: begin
        o_ld_state      = 1'b1;
        o_write_enb_reg = 1'b1;
      end
      ST_LP: begin
        o_write_enb_reg = 1'b1;
        o_busy          = 1'b1;
      end
      ST_FFS: begin
        o_full_state = 1'b1;
        o_busy       = 1'b1;
      end
      ST_LAF: begin
        o_laf_state     = 1'b1;
        o_write_enb_reg = 1'b1;
        o_busy          = 1'b1;
      end
      ST_CPE: begin
        o_rst_int_reg = 1'b1;
        o_busy        = 1'b1;
      end
      ST_DROP: o_drop_state = 1'b1;
      default: o_detect_add = 1'b0;
    endcase
  end

  assign o_dest_addr = r_dest;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: per-cycle expected decodes queued and compared after each edge.
module tb_router_fsm_np;

  localparam int NP = 3;
  localparam int AW = 2;
  localparam int WT = 4;
  localparam int TW = 6;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, drop, aborted}
  localparam logic [9:0] V_DEC  = 10'b1000000000;
  localparam logic [9:0] V_WAIT = 10'b0000000100;
  localparam logic [9:0] V_LFD  = 10'b0100000100;
  localparam logic [9:0] V_LD   = 10'b0010001000;
  localparam logic [9:0] V_LP   = 10'b0000001100;
  localparam logic [9:0] V_FFS  = 10'b0000100100;
  localparam logic [9:0] V_LAF  = 10'b0001001100;
  localparam logic [9:0] V_CPE  = 10'b0000010100;
  localparam logic [9:0] V_DROP = 10'b0000000010;
  localparam logic [9:0] V_ABT  = 10'b0000000001;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pv = 1'b0;
  logic [AW-1:0] din = '0;
  logic [NP-1:0] full = '0;
  logic [NP-1:0] empty = '1;
  logic [NP-1:0] srst = '0;
  logic          pd = 1'b0;
  logic          lpv = 1'b0;

  logic          detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic          write_enb_reg, busy, drop_state, aborted;
  logic [AW-1:0] dest_addr;

  router_fsm_np #(
    .NUM_PORTS    (NP),
    .ADDR_W       (AW),
    .WAIT_TIMEOUT (WT),
    .TMR_W        (TW)
  ) dut (
    .i_clk              (clk),
    .i_resetn           (resetn),
    .i_packet_valid     (pv),
    .i_datain           (din),
    .i_fifo_full        (full),
    .i_fifo_empty       (empty),
    .i_soft_reset       (srst),
    .i_parity_done      (pd),
    .i_low_packet_valid (lpv),
    .o_detect_add       (detect_add),
    .o_lfd_state        (lfd_state),
    .o_ld_state         (ld_state),
    .o_laf_state        (laf_state),
    .o_full_state       (full_state),
    .o_rst_int_reg      (rst_int_reg),
    .o_write_enb_reg    (write_enb_reg),
    .o_busy             (busy),
    .o_drop_state       (drop_state),
    .o_dest_addr        (dest_addr),
    .o_aborted          (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [9:0]    vec;
    logic [AW-1:0] dest;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_dest = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
            write_enb_reg, busy, drop_state, aborted};
  endfunction

  task automatic step(input string tag, input logic [9:0] v);
    exp_t e;
    e.tag  = tag;
    e.vec  = v;
    e.dest = exp_dest;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, "/dec"}, 32'(obs_vec()), 32'(e.vec));
    chk({e.tag, "/dest"}, 32'(dest_addr), 32'(e.dest));
  endtask

  task automatic hdr(input logic [AW-1:0] a);
    pv       = 1'b1;
    din      = a;
    exp_dest = a;
  endtask

  initial begin
    #12;
    chk("rst/dec", 32'(obs_vec()), 32'(V_DEC));
    chk("rst/dest", 32'(dest_addr), 32'd0);
    resetn = 1'b1;

    // normal packet to port 1: four payload cycles then parity
    hdr(2'd1);
    step("n_lfd", V_LFD);
    for (int i = 0; i < 4; i++) step("n_ld", V_LD);
    pv = 1'b0;
    step("n_lp", V_LP);
    step("n_cpe", V_CPE);
    step("n_dec", V_DEC);

    // header to a non-existent port
    hdr(2'd3);
    step("d_drop", V_DROP);
    step("d_hold", V_DROP);
    pv = 1'b0;
    step("d_dec", V_DEC);

    // wait timeout
    empty = 3'b011;
    hdr(2'd2);
    for (int i = 0; i < WT; i++) step("t_wait", V_WAIT);
    step("t_drop", V_DROP | V_ABT);
    step("t_hold", V_DROP);
    pv = 1'b0;
    step("t_dec", V_DEC);

    // destination drains before the timeout
    hdr(2'd2);
    for (int i = 0; i < 3; i++) step("e_wait", V_WAIT);
    empty = 3'b111;
    step("e_lfd", V_LFD);
    step("e_ld", V_LD);
    pv = 1'b0;
    step("e_lp", V_LP);
    step("e_cpe", V_CPE);
    step("e_dec", V_DEC);

    // full, resume, low_packet_valid, then full again at parity check
    hdr(2'd0);
    step("f_lfd", V_LFD);
    step("f_ld", V_LD);
    full = 3'b001;
    step("f_ffs", V_FFS);
    step("f_ffs2", V_FFS);
    full = 3'b000;
    step("f_laf", V_LAF);
    lpv = 1'b1;
    pv  = 1'b0;
    step("f_lp", V_LP);
    lpv  = 1'b0;
    full = 3'b001;
    step("f_cpe", V_CPE);
    step("f_cpe_ffs", V_FFS);
    full = 3'b000;
    step("f_laf2", V_LAF);
    pd = 1'b1;
    step("f_pd_dec", V_DEC);
    pd = 1'b0;

    // LAF back to LD, then parity_done straight to decode
    hdr(2'd0);
    step("p_lfd", V_LFD);
    step("p_ld", V_LD);
    full = 3'b001;
    step("p_ffs", V_FFS);
    full = 3'b000;
    step("p_laf", V_LAF);
    step("p_ld2", V_LD);
    full = 3'b001;
    step("p_ffs2", V_FFS);
    full = 3'b000;
    step("p_laf2", V_LAF);
    pd = 1'b1;
    pv = 1'b0;
    step("p_dec", V_DEC);
    pd = 1'b0;

    // soft reset in LD, ignoring a non-destination port
    hdr(2'd1);
    step("s_lfd", V_LFD);
    step("s_ld", V_LD);
    srst = 3'b100;
    step("s_other", V_LD);
    srst = 3'b010;
    pv   = 1'b0;
    step("s_abort_ld", V_DEC | V_ABT);
    srst = 3'b000;
    step("s_clear", V_DEC);

    // soft reset in FIFO_FULL_STATE
    hdr(2'd1);
    step("s2_lfd", V_LFD);
    step("s2_ld", V_LD);
    full = 3'b010;
    step("s2_ffs", V_FFS);
    srst = 3'b010;
    pv   = 1'b0;
    step("s2_abort", V_DEC | V_ABT);
    srst = 3'b000;
    full = 3'b000;
    step("s2_clear", V_DEC);

    // soft reset while waiting for empty
    empty = 3'b011;
    hdr(2'd2);
    step("s3_wait", V_WAIT);
    srst = 3'b100;
    pv   = 1'b0;
    step("s3_abort", V_DEC | V_ABT);
    srst  = 3'b000;
    empty = 3'b111;
    step("s3_clear", V_DEC);

    // asynchronous reset in the middle of a payload
    hdr(2'd2);
    step("r_lfd", V_LFD);
    step("r_ld", V_LD);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar/detect_add", 32'(detect_add), 32'd1);
    chk("ar/busy", 32'(busy), 32'd0);
    chk("ar/dest", 32'(dest_addr), 32'd0);
    chk("ar/aborted", 32'(aborted), 32'd0);
    pv       = 1'b0;
    exp_dest = '0;
    @(negedge clk);
    resetn = 1'b1;
    step("r_dec", V_DEC);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
